grid_sprite_mover: RTL and testbench

- Parametrised, tile-grid successor to the player movement controller. Moves one sprite (the player, or a ghost fed by an AI direction source) through a COLS x ROWS tile maze at a programmable speed.
- Buffers a pending turn, allows instant reversal, supports optional edge wrap (tunnels), and reads walls through a 1-cycle-latency tile-map port instead of a full pixel array.
- Sits between the input/AI logic and the renderer, pellet and collision logic.

---
 rtl/grid_sprite_mover.sv | 229 ++++++++++++++++++++++
 tb/tb_grid_sprite_mover.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/grid_sprite_mover.sv
// Tile-grid sprite mover: prescaled stepping, buffered turns,
// instant reversal, optional edge wrap, 1-cycle tile-map wall lookups.
module grid_sprite_mover #(
  parameter int TILE_PX   = 8,
  parameter int COLS      = 28,
  parameter int ROWS      = 31,
  parameter int COL_W     = 5,
  parameter int ROW_W     = 5,
  parameter int PIX_W     = 10,
  parameter int SPEED_DIV = 5,
  parameter int START_COL = 1,
  parameter int START_ROW = 1,
  parameter int START_DIR = 2,
  parameter int WRAP_EN   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             freeze,
  input  logic             restart,
  input  logic [3:0]       dir_req,
  output logic             wall_rd_en,
  output logic [COL_W-1:0] wall_col,
  output logic [ROW_W-1:0] wall_row,
  input  logic             wall_rd_data,
  output logic [PIX_W-1:0] pos_x,
  output logic [PIX_W-1:0] pos_y,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [1:0]       dir,
  output logic             moving,
  output logic             tile_enter,
  output logic             blocked
);

  localparam int OFF_W = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
  localparam int PS_W  = $clog2(SPEED_DIV);
  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(TILE_PX - 1);
  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(SPEED_DIV - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [1:0] D_L = 2'd0;
  localparam logic [1:0] D_U = 2'd1;
  localparam logic [1:0] D_R = 2'd2;
  localparam logic [1:0] D_D = 2'd3;

  typedef enum logic [2:0] {
    WAIT, LOOK_P, CHK_P, LOOK_C, CHK_C
  } state_t;

  state_t           state, state_n;
  logic [OFF_W-1:0] off_x, off_y, off_x_n, off_y_n;
  logic [COL_W-1:0] col_n, nb_col;
  logic [ROW_W-1:0] row_n, nb_row;
  logic [1:0]       dir_n, pend, pend_n, ld, lk_dir;
  logic [1:0]       req_dir, step_dir;
  logic [PS_W-1:0]  ps, ps_n;
  logic             moving_n, blocked_n, te_n;
  logic             req_ok, run, tick, aligned;
  logic             nb_off, do_step;

  assign run     = enable & ~freeze;
  assign tick    = run && (ps == PS_MAX);
  assign aligned = (off_x == '0) && (off_y == '0);
  assign ps_n    = !run ? ps : (ps == PS_MAX) ? '0 : ps + 1'b1;

  assign pos_x = PIX_W'({col, off_x});
  assign pos_y = PIX_W'({row, off_y});

  assign wall_rd_en = ((state == LOOK_P) || (state == LOOK_C)) && !nb_off;
  assign wall_col   = nb_col;
  assign wall_row   = nb_row;

  always_comb begin
    req_ok  = 1'b1;
    req_dir = D_L;
    case (dir_req)
      4'b0001: req_dir = D_L;
      4'b0010: req_dir = D_U;
      4'b0100: req_dir = D_R;
      4'b1000: req_dir = D_D;
      default: req_ok  = 1'b0;
    endcase
    pend_n = req_ok ? req_dir : pend;
  end

  // Neighbour of the direction under lookup; off-grid only without wrap.
  always_comb begin
    lk_dir = (state == LOOK_P) ? pend : dir;
    nb_col = col;
    nb_row = row;
    nb_off = 1'b0;
    case (lk_dir)
      D_L:
        if (col == '0) begin
          nb_off = (WRAP_EN == 0);
          nb_col = COL_MAX;
        end else nb_col = col - 1'b1;
      D_R:
        if (col == COL_MAX) begin
          nb_off = (WRAP_EN == 0);
          nb_col = '0;
        end else nb_col = col + 1'b1;
      D_U:
        if (row == '0) begin
          nb_off = (WRAP_EN == 0);
          nb_row = ROW_MAX;
        end else nb_row = row - 1'b1;
      default:
        if (row == ROW_MAX) begin
          nb_off = (WRAP_EN == 0);
          nb_row = '0;
        end else nb_row = row + 1'b1;
    endcase
  end

  always_comb begin
    state_n   = state;
    dir_n     = dir;
    moving_n  = moving;
    blocked_n = blocked;
    do_step   = 1'b0;
    step_dir  = dir;
    unique case (state)
      WAIT:
        if (tick) begin
          if (aligned) state_n = LOOK_P;
          else begin
            if (pend == (dir ^ 2'd2)) begin
              dir_n    = pend;
              step_dir = pend;
            end
            do_step = 1'b1;
          end
        end
      LOOK_P: state_n = nb_off ? LOOK_C : CHK_P;
      CHK_P:
        if (!wall_rd_data) begin
          dir_n     = ld;
          moving_n  = 1'b1;
          blocked_n = 1'b0;
          step_dir  = ld;
          do_step   = run;
          state_n   = WAIT;
        end else if (ld == dir) begin
          moving_n  = 1'b0;
          blocked_n = 1'b1;
          state_n   = WAIT;
        end else state_n = LOOK_C;
      LOOK_C:
        if (nb_off) begin
          moving_n  = 1'b0;
          blocked_n = 1'b1;
          state_n   = WAIT;
        end else state_n = CHK_C;
      CHK_C: begin
        moving_n  = !wall_rd_data;
        blocked_n = wall_rd_data;
        do_step   = run && !wall_rd_data;
        state_n   = WAIT;
      end
      default: state_n = WAIT;
    endcase
  end

  // Stepping; index wrap is only reachable when the lookup allowed it.
  always_comb begin
    off_x_n = off_x;
    off_y_n = off_y;
    col_n   = col;
    row_n   = row;
    if (do_step) begin
      case (step_dir)
        D_L:
          if (off_x == '0) begin
            off_x_n = OFF_MAX;
            col_n   = (col == '0) ? COL_MAX : col - 1'b1;
          end else off_x_n = off_x - 1'b1;
        D_R:
          if (off_x == OFF_MAX) begin
            off_x_n = '0;
            col_n   = (col == COL_MAX) ? '0 : col + 1'b1;
          end else off_x_n = off_x + 1'b1;
        D_U:
          if (off_y == '0) begin
            off_y_n = OFF_MAX;
            row_n   = (row == '0) ? ROW_MAX : row - 1'b1;
          end else off_y_n = off_y - 1'b1;
        default:
          if (off_y == OFF_MAX) begin
            off_y_n = '0;
            row_n   = (row == ROW_MAX) ? '0 : row + 1'b1;
          end else off_y_n = off_y + 1'b1;
      endcase
    end
    te_n = do_step && (off_x_n == '0) && (off_y_n == '0);
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state      <= WAIT;
      col        <= COL_W'(START_COL);
      row        <= ROW_W'(START_ROW);
      off_x      <= '0;
      off_y      <= '0;
      dir        <= 2'(START_DIR);
      pend       <= 2'(START_DIR);
      ld         <= 2'(START_DIR);
      moving     <= 1'b0;
      blocked    <= 1'b0;
      tile_enter <= 1'b0;
      ps         <= '0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      row        <= row_n;
      off_x      <= off_x_n;
      off_y      <= off_y_n;
      dir        <= dir_n;
      pend       <= pend_n;
      if (state == LOOK_P) ld <= pend;
      moving     <= moving_n;
      blocked    <= blocked_n;
      tile_enter <= te_n;
      ps         <= ps_n;
    end
  end

endmodule

// File: tb/tb_grid_sprite_mover.sv
// Directed bench for grid_sprite_mover: default grid instance plus a
// wrap-enabled instance starting at column 0 heading left.
module tb_grid_sprite_mover;

  logic clk = 1'b0;
  logic reset, enable, freeze, restart;
  logic [3:0] dir_req;

  logic       rd_en, rd_data;
  logic [4:0] rd_col, rd_row, col, row;
  logic [9:0] pos_x, pos_y;
  logic [1:0] dir;
  logic       moving, tile_enter, blocked;

  logic       w_rd_en;
  logic       w_rd_data;
  logic [4:0] w_rd_col, w_rd_row, w_col, w_row;
  logic [9:0] w_pos_x, w_pos_y;
  logic [1:0] w_dir;
  logic       w_moving, w_tile_enter, w_blocked;

  logic walls [31][28];
  int   rd_cnt;
  logic [4:0] last_col, last_row;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  grid_sprite_mover dut (
    .clk(clk), .reset(reset), .enable(enable), .freeze(freeze),
    .restart(restart), .dir_req(dir_req),
    .wall_rd_en(rd_en), .wall_col(rd_col), .wall_row(rd_row),
    .wall_rd_data(rd_data),
    .pos_x(pos_x), .pos_y(pos_y), .col(col), .row(row), .dir(dir),
    .moving(moving), .tile_enter(tile_enter), .blocked(blocked)
  );

  grid_sprite_mover #(
    .START_COL(0), .START_DIR(0), .WRAP_EN(1)
  ) u_w (
    .clk(clk), .reset(reset), .enable(enable), .freeze(freeze),
    .restart(restart), .dir_req(dir_req),
    .wall_rd_en(w_rd_en), .wall_col(w_rd_col), .wall_row(w_rd_row),
    .wall_rd_data(w_rd_data),
    .pos_x(w_pos_x), .pos_y(w_pos_y), .col(w_col), .row(w_row),
    .dir(w_dir), .moving(w_moving), .tile_enter(w_tile_enter),
    .blocked(w_blocked)
  );

  assign w_rd_data = 1'b0;

  always @(posedge clk) begin
    rd_data <= rd_en ? walls[rd_row][rd_col] : 1'b0;
    if (reset) rd_cnt <= 0;
    else if (rd_en) begin
      rd_cnt   <= rd_cnt + 1;
      last_col <= rd_col;
      last_row <= rd_row;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic corridor();
    for (int r = 0; r < 31; r++)
      for (int c = 0; c < 28; c++)
        walls[r][c] = !(r == 1 && c >= 1 && c <= 26);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    enable  = 1'b1;
    freeze  = 1'b0;
    restart = 1'b0;
    dir_req = 4'b0000;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic wait_px(input int px);
    for (int i = 0; i < 100 && pos_x != 10'(px); i++) cyc(1);
  endtask

  initial begin
    int c0;
    // 1: reset state, first lookup and first step, tile_enter
    corridor();
    do_reset();
    chk("rst_col", col, 1);
    chk("rst_row", row, 1);
    chk("rst_dir", dir, 2);
    chk("rst_mov", moving, 0);
    chk("rst_blk", blocked, 0);
    chk("rst_pos_x", pos_x, 8);
    chk("rst_pos_y", pos_y, 8);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_te", tile_enter, 0);
    cyc(5);
    chk("t1_rd_en", rd_en, 1);
    chk("t1_rd_col", rd_col, 2);
    chk("t1_rd_row", rd_row, 1);
    cyc(1);
    chk("t1_pre_x", pos_x, 8);
    cyc(1);
    chk("t1_step_x", pos_x, 9);
    chk("t1_moving", moving, 1);
    for (int i = 0; i < 100 && !tile_enter; i++) cyc(1);
    chk("t1_te_seen", tile_enter, 1);
    chk("t1_te_x", pos_x, 16);
    chk("t1_te_col", col, 2);
    cyc(1);
    chk("t1_te_pulse", tile_enter, 0);

    // 2: wall straight ahead, no request
    corridor();
    walls[1][2] = 1'b1;
    do_reset();
    for (int i = 0; i < 30 && !blocked; i++) cyc(1);
    chk("t2_blocked", blocked, 1);
    chk("t2_reads", rd_cnt, 1);
    chk("t2_rd_col", last_col, 2);
    chk("t2_rd_row", last_row, 1);
    chk("t2_moving", moving, 0);
    cyc(20);
    chk("t2_hold_x", pos_x, 8);

    // 3: mid-tile reversal without lookup
    corridor();
    do_reset();
    wait_px(11);
    chk("t3_at11", pos_x, 11);
    dir_req = 4'b0001;
    c0 = rd_cnt;
    for (int i = 0; i < 20 && pos_x == 10'd11; i++) cyc(1);
    dir_req = 4'b0000;
    chk("t3_dir", dir, 0);
    chk("t3_pos_x", pos_x, 10);
    chk("t3_no_rd", rd_cnt, c0);

    // 4: buffered turn up at column 2
    corridor();
    walls[0][2] = 1'b0;
    do_reset();
    wait_px(10);
    dir_req = 4'b0010;
    cyc(1);
    dir_req = 4'b0000;
    for (int i = 0; i < 100 && !rd_en; i++) cyc(1);
    chk("t4_rd_col", rd_col, 2);
    chk("t4_rd_row", rd_row, 0);
    for (int i = 0; i < 20 && pos_y == 10'd8; i++) cyc(1);
    chk("t4_dir", dir, 1);
    chk("t4_pos_y", pos_y, 7);
    chk("t4_row", row, 0);
    chk("t4_pos_x", pos_x, 16);

    // 5: wrap instance leaves column 0 to the left
    do_reset();
    chk("t5_rst_x", w_pos_x, 0);
    cyc(5);
    chk("t5_rd_en", w_rd_en, 1);
    chk("t5_rd_col", w_rd_col, 27);
    chk("t5_rd_row", w_rd_row, 1);
    for (int i = 0; i < 20 && w_pos_x == 10'd0; i++) cyc(1);
    chk("t5_col", w_col, 27);
    chk("t5_pos_x", w_pos_x, 223);

    // 6: freeze holds position, restart returns to start
    corridor();
    do_reset();
    wait_px(11);
    freeze = 1'b1;
    cyc(20);
    chk("t6_frz_x", pos_x, 11);
    chk("t6_frz_col", col, 1);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    freeze  = 1'b0;
    chk("t6_col", col, 1);
    chk("t6_row", row, 1);
    chk("t6_dir", dir, 2);
    chk("t6_mov", moving, 0);
    chk("t6_pos_x", pos_x, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
